// File: rtl/pl_dmem_pkg.sv
// ---------------------------------------------------------------------------
// pl_dmem_pkg
// Shared constants for the data-memory arbiter slice.
//   - FSM state encodings (IDLE / ACCESS / RESP)
//   - one-hot grant encodings for the two requesters
//   - default width of the address window decoded by the memory block
// No ports; imported by pl_dmem_arbiter.
// ---------------------------------------------------------------------------
package pl_dmem_pkg;

   // FSM state encodings
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   // One-hot transaction owner; GNT_NONE while the port is idle
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_R0   = 2'b01;
   localparam logic [1:0] GNT_R1   = 2'b10;

   // Low address bits decoded by the memory block; anything above is out of window
   localparam int WIN_BITS_DEF = 8;

endpackage

// File: rtl/pl_dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   req  [1:0] in   pending requests (bit 0 = requester 0)
//   last       in   index of the requester granted most recently
//   gnt  [1:0] out  one-hot winner, 00 when no request is pending
// On a tie the requester that is not 'last' wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // Tie: hand the port to whoever did not have it last
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/pl_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// pl_dmem_arbiter
// Two-requester round-robin arbiter and sequencer in front of the
// data-memory / I-O block. Requester 0 is the pipeline MEM stage,
// requester 1 the I/O DMA/loader. One access at a time:
//   IDLE   -> pick a winner, latch its request
//   ACCESS -> drive the memory port from the latches, capture dataout
//   RESP   -> one-cycle ack to the owner; may hand over directly to
//             the other requester
// Ports:
//   clock, clrn                   clock (rising edge), sync active-low reset
//   rN_req/we/addr/wdata          requester N request (held until rN_ack)
//   rN_ack/rdata/err              requester N one-cycle response
//   mem_addr/datain/we            shared memory port (registered sources)
//   mem_dataout                   memory read data
//   grant                         one-hot current owner, 00 when idle
// ---------------------------------------------------------------------------
module pl_dmem_arbiter
   import pl_dmem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WIN_BITS = WIN_BITS_DEF
) (
   input  logic              clock,
   input  logic              clrn,

   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,

   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_datain,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dataout,

   output logic [1:0]        grant
);

   // ---------------------------------------------------------------
   // State and latches
   // ---------------------------------------------------------------
   logic [1:0]        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              last_q,  last_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q,    we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q,   err_d;

   logic [1:0]        arb_req;
   logic [1:0]        arb_gnt;
   logic              out_of_window;
   logic              in_access;
   logic              in_resp;

   assign in_access     = (state_q == S_ACCESS);
   assign in_resp       = (state_q == S_RESP);
   // Any set bit above the decoded window means the memory block would alias
   assign out_of_window = |addr_q[ADDR_W-1:WIN_BITS];

   // ---------------------------------------------------------------
   // Arbitration
   // In RESP the owner's req still belongs to the transaction being
   // acknowledged, so it is masked; only the other requester can win
   // a direct hand-over. Elsewhere than IDLE/RESP nobody can win.
   // ---------------------------------------------------------------
   always_comb begin
      arb_req = 2'b00;
      case (state_q)
         S_IDLE:  arb_req = {r1_req, r0_req};
         S_RESP:  arb_req = {r1_req, r0_req} & ~grant_q;
         default: arb_req = 2'b00;
      endcase
   end

   rr_arb2 u_rr_arb2 (
      .req  (arb_req),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE, S_RESP: begin
            if (arb_gnt != GNT_NONE) begin
               grant_d = arb_gnt;
               last_d  = (arb_gnt == GNT_R1);
               if (arb_gnt == GNT_R1) begin
                  addr_d  = r1_addr;
                  wdata_d = r1_wdata;
                  we_d    = r1_we;
               end else begin
                  addr_d  = r0_addr;
                  wdata_d = r0_wdata;
                  we_d    = r0_we;
               end
               state_d = S_ACCESS;
            end else begin
               grant_d = GNT_NONE;
               state_d = S_IDLE;
            end
         end

         S_ACCESS: begin
            err_d = out_of_window;
            // Writes and rejected accesses return zero rather than
            // whatever the memory happens to present on dataout
            if (out_of_window || we_q) begin
               rdata_d = '0;
            end else begin
               rdata_d = mem_dataout;
            end
            state_d = S_RESP;
         end

         default: begin
            grant_d = GNT_NONE;
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         grant_q <= GNT_NONE;
         last_q  <= 1'b1;     // requester 0 wins the first tie
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // The memory port is driven straight from the latches, so the
   // requesters are free to change their inputs once granted. The
   // write strobe exists only in ACCESS, which always lasts a single
   // cycle and is always followed by RESP.
   // ---------------------------------------------------------------
   assign mem_addr   = addr_q;
   assign mem_datain = wdata_q;
   assign mem_we     = in_access && we_q && !out_of_window;

   assign grant      = grant_q;

   assign r0_ack     = in_resp && (grant_q == GNT_R0);
   assign r1_ack     = in_resp && (grant_q == GNT_R1);
   assign r0_err     = r0_ack && err_q;
   assign r1_err     = r1_ack && err_q;
   assign r0_rdata   = rdata_q;
   assign r1_rdata   = rdata_q;

endmodule

// File: doc/pl_dmem_arbiter.md
Name: pl_dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the data-memory/I-O block, which takes addr, datain, we and returns dataout.
- Requester 0 is the pipeline MEM stage. Requester 1 is the I/O DMA/loader.
- Grants one access at a time, round-robin, and drives the shared memory port from registered copies of the winner's request.
- Returns read data with a one-cycle ack pulse, and rejects out-of-window addresses without touching memory.

Parameters:
ADDR_W, 32, requester/memory address width
DATA_W, 32, data width
WIN_BITS, 8, low address bits decoded by the memory block; any 1 in addr[ADDR_W-1:WIN_BITS] is out of window

Ports:
clock  in  1  system clock (rising edge)
clrn  in  1  reset; one clock; reset is synchronous and active-low
r0_req  in  1  requester 0 access request, held until r0_ack
r0_we  in  1  requester 0 write (1) / read (0)
r0_addr  in  ADDR_W  requester 0 byte address
r0_wdata  in  DATA_W  requester 0 write data
r0_ack  out  1  one-cycle completion pulse
r0_rdata  out  DATA_W  read data, valid while r0_ack=1
r0_err  out  1  out-of-window flag, valid while r0_ack=1
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_err: same as requester 0, for requester 1
mem_addr  out  ADDR_W  to memory block addr
mem_datain  out  DATA_W  to memory block datain
mem_we  out  1  to memory block we
mem_dataout  in  DATA_W  from memory block dataout
grant  out  2  one-hot owner of the current transaction; 00 when idle

Behaviour:
- Reset (clrn=0 at a rising edge), all values held until the first edge with clrn=1:
  - state=IDLE; last=1, so requester 0 wins the first tie.
  - All acks, errs and mem_we are 0; rdata, mem_addr and mem_datain are 0; grant=00.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample r0_req and r1_req.
  - Neither set: stay in IDLE.
  - One set: grant that requester.
  - Both set: grant the requester not equal to last.
  - On a grant: latch the winner's addr, wdata and we into the request registers, set grant, update last, go to ACCESS.
- ACCESS (one cycle):
  - mem_addr and mem_datain are driven from the latched values.
  - In window: mem_we = latched we. Out of window: mem_we = 0 and err_pending is set.
  - At the closing edge, capture mem_dataout into rdata. An out-of-window access or a write captures 0 instead.
  - Next state: RESP.
- RESP (one cycle):
  - The owner's ack=1, with rdata and err valid. mem_we=0 throughout RESP.
  - The owner's req sampled in this cycle belongs to the finished transaction and is ignored.
  - If the other requester's req=1, grant it directly and go to ACCESS; otherwise go to IDLE and set grant=00.
- Latency: request accepted in IDLE at cycle t → ack at t+2. Best-case back-to-back (alternating requesters) gives one access per 2 cycles.
- A requester that re-asserts req after its ack waits at least until the next IDLE or the other requester's RESP. This guarantees no starvation: the waiting requester is served within 3 cycles of its request being sampled.
- mem_we is high only in ACCESS, for exactly one cycle per in-window write. It is never high in two consecutive cycles.
- The memory block's I/O split (I/O selected when addr bit 7 is set) is transparent to this block. I/O addresses are forwarded unchanged.
- Requester inputs may change in ACCESS or RESP without effect, because all memory-side values come from the latches.
- Reset mid-transaction drops the transaction: no ack is issued, and mem_we falls to 0 at the reset edge.
- Requests arriving in the same cycle reset is released are sampled at the first edge with clrn=1.

Decomposition:
- Shared package pl_dmem_pkg holds:
  - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2;
  - the grant one-hot constants;
  - the WIN_BITS default.
- One sub-module, rr_arb2: combinational 2-way round-robin picker with inputs req[1:0] and last, and output gnt[1:0].
- The FSM, request latches and response registers stay in the top level.

Test Plan:
- Reset, then r0 write 0x0000_0010 ← 0xDEAD_BEEF: mem_we=1 for exactly one cycle, r0_ack at cycle t+2. A following r0 read of 0x10 returns r0_rdata=0xDEAD_BEEF with r0_err=0.
- r0_req and r1_req both held from reset release: grant order r0, r1, r0, r1, with acks at cycles 2, 4, 6, 8 after the first sample; neither ack is ever missed.
- r1 read of I/O address 0x0000_0080 with the memory model returning 0x0000_1234: the request is forwarded unchanged and r1_rdata=0x0000_1234.
- r0 write to 0x0000_0100 (out of window): mem_we stays 0 for the whole transaction; r0_ack=1 with r0_err=1 and r0_rdata=0.
- clrn pulled low during ACCESS of an r1 write: no r1_ack; mem_we=0 from the reset edge; all outputs at their reset values; the next request after release completes normally.
- r0_req stays high across its ack while r1 is idle: the second r0 transaction starts from IDLE, so acks land 3 cycles apart. This confirms the sample in RESP was ignored.
